// File: rtl/cic_int.sv
`timescale 1ns/1ps
// cic_int: CIC interpolator. N combs at the input rate, zero-stuff by R, N integrators at clk rate.
// Optional sticky underflow flag on port uflow when CIC_INT_UFLOW_EN is defined.
module cic_int #(
    parameter int unsigned R          = 4,
    parameter int unsigned M          = 1,
    parameter int unsigned N          = 2,
    parameter int unsigned BIN        = 10,
    parameter int unsigned BOUT       = 12,
    parameter int unsigned COUT       = 8,
    parameter string       CUT_METHOD = "ROUND"
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable_cic,
    input  logic signed [BIN-1:0]  din,
    input  logic                   din_vld,
    output logic                   din_rdy,
    output logic signed [BOUT-1:0] dout,
    output logic signed [COUT-1:0] dout_cut,
    output logic                   dout_vld
`ifdef CIC_INT_UFLOW_EN
    ,
    output logic                   uflow
`endif
);

    localparam int unsigned CW = $clog2(R);
    localparam int unsigned SH = BOUT - COUT;

    logic [CW-1:0]          cnt;
    logic                   slot;
    logic                   primed;
    logic                   primed_nxt;
    logic signed [BOUT-1:0] x;
    logic signed [BOUT-1:0] acc;
    logic signed [BOUT-1:0] comb_out;
    logic signed [BOUT-1:0] stage_in [N];
    logic signed [BOUT-1:0] dl       [N][M];
    logic signed [BOUT-1:0] up;
    logic signed [BOUT-1:0] integ    [N];
    logic [N:0]             vpipe;

    assign slot       = enable_cic && (cnt == '0);
    assign din_rdy    = slot;
    assign x          = din_vld ? BOUT'(din) : '0;
    assign primed_nxt = primed | (slot & din_vld);

    // Phase counter: one sample slot every R enabled clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (enable_cic) begin
            cnt <= (cnt == CW'(R - 1)) ? '0 : cnt + CW'(1);
        end
    end

    // Comb chain; a running accumulator keeps the chain free of self-referencing arrays
    always_comb begin
        acc = x;
        for (int j = 0; j < N; j++) begin
            stage_in[j] = acc;
            acc         = acc - dl[j][M-1];
        end
        comb_out = acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N; j++) begin
                for (int k = 0; k < M; k++) begin
                    dl[j][k] <= '0;
                end
            end
        end else if (slot) begin
            for (int j = 0; j < N; j++) begin
                dl[j][0] <= stage_in[j];
                for (int k = 1; k < M; k++) begin
                    dl[j][k] <= dl[j][k-1];
                end
            end
        end
    end

    // Zero-stuffing, integrators and the valid pipeline all advance on enabled clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            up     <= '0;
            vpipe  <= '0;
            primed <= 1'b0;
            for (int i = 0; i < N; i++) begin
                integ[i] <= '0;
            end
        end else if (enable_cic) begin
            up       <= slot ? comb_out : '0;
            integ[0] <= integ[0] + up;
            for (int i = 1; i < N; i++) begin
                integ[i] <= integ[i] + integ[i-1];
            end
            vpipe  <= {vpipe[N-1:0], primed_nxt};
            primed <= primed_nxt;
        end
    end

    assign dout     = integ[N-1];
    assign dout_vld = vpipe[N] && enable_cic;

`ifdef CIC_INT_UFLOW_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            uflow <= 1'b0;
        end else if (slot && !din_vld && primed) begin
            uflow <= 1'b1;
        end
    end
`endif

    generate
        if (CUT_METHOD == "ROUND") begin : g_round
            logic signed [COUT-1:0] kept;
            logic                   b;
            logic                   low_any;
            logic                   carry;

            assign kept = dout[BOUT-1 -: COUT];
            assign b    = dout[SH-1];
            if (SH > 1) begin : g_low
                assign low_any = |dout[SH-2:0];
            end else begin : g_nolow
                assign low_any = 1'b0;
            end
            // Half rounds away from zero: negative ties must not carry
            assign carry    = dout[BOUT-1] ? (b & low_any) : b;
            assign dout_cut = kept + COUT'(carry);
        end else begin : g_cut
            assign dout_cut = COUT'(dout >>> SH);
        end
    endgenerate

endmodule

// File: tb/tb_cic_int.sv
`timescale 1ns/1ps
// tb_cic_int: two cic_int instances (M=1 ROUND, M=2 CUT) share stimulus; a scoreboard built from
// the CIC impulse response (convolution of boxcars) predicts every valid output.
module tb_cic_int;
    localparam int R     = 4;
    localparam int N     = 2;
    localparam int BIN   = 10;
    localparam int M1    = 1;
    localparam int BOUT1 = 12;
    localparam int COUT1 = 10;
    localparam int M2    = 2;
    localparam int BOUT2 = 14;
    localparam int COUT2 = 12;

    typedef longint lq_t[$];

    logic clk = 1'b0;
    logic rst, enable_cic, din_vld;
    logic signed [BIN-1:0] din;
    logic din_rdy, din_rdy2, dout_vld, dout_vld2;
    logic signed [BOUT1-1:0] dout;
    logic signed [COUT1-1:0] dout_cut;
    logic signed [BOUT2-1:0] dout2;
    logic signed [COUT2-1:0] dout_cut2;
`ifdef CIC_INT_UFLOW_EN
    logic uflow, uflow2;
`endif

    always #5 clk = ~clk;

    cic_int #(.R(R), .M(M1), .N(N), .BIN(BIN), .BOUT(BOUT1), .COUT(COUT1), .CUT_METHOD("ROUND")) u_dut (
        .clk(clk), .rst(rst), .enable_cic(enable_cic), .din(din), .din_vld(din_vld),
        .din_rdy(din_rdy), .dout(dout), .dout_cut(dout_cut), .dout_vld(dout_vld)
`ifdef CIC_INT_UFLOW_EN
        , .uflow(uflow)
`endif
    );

    cic_int #(.R(R), .M(M2), .N(N), .BIN(BIN), .BOUT(BOUT2), .COUT(COUT2), .CUT_METHOD("CUT")) u_dut2 (
        .clk(clk), .rst(rst), .enable_cic(enable_cic), .din(din), .din_vld(din_vld),
        .din_rdy(din_rdy2), .dout(dout2), .dout_cut(dout_cut2), .dout_vld(dout_vld2)
`ifdef CIC_INT_UFLOW_EN
        , .uflow(uflow2)
`endif
    );

    int     n_tests, n_fail;
    int     ph, pcnt, acc_cnt;
    bit     primed_m, uflow_m, just_rst, rst_g, en_g, cap;
    lq_t    h1, h2;
    longint hist[$];
    longint q1[$], q2[$];
    longint cap1[$], cap2[$];
    int     src_q[$];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic lq_t box_pow(input int rm);
        lq_t h, t;
        longint s;
        h.push_back(1);
        repeat (N) begin
            t = {};
            for (int i = 0; i < h.size() + rm - 1; i++) begin
                s = 0;
                for (int j = 0; j < rm; j++)
                    if (i - j >= 0 && i - j < h.size()) s += h[i-j];
                t.push_back(s);
            end
            h = t;
        end
        return h;
    endfunction

    function automatic longint wrapw(input longint v, input int w);
        longint m;
        m = longint'(1) << w;
        v = v % m;
        if (v < 0) v += m;
        if (v >= m / 2) v -= m;
        return v;
    endfunction

    function automatic longint conv(input bit second);
        longint s;
        s = 0;
        for (int k = 0; k < hist.size(); k++) begin
            if (second && k < h2.size()) s += h2[k] * hist[k];
            if (!second && k < h1.size()) s += h1[k] * hist[k];
        end
        return s;
    endfunction

    // Round half away from zero, or floor, then wrap to w bits
    function automatic longint cut_exp(input longint y, input int s, input int w, input bit rnd);
        longint a, q, d;
        d = longint'(1) << s;
        if (rnd) begin
            a = (y < 0) ? -y : y;
            q = (a + d / 2) / d;
            if (y < 0) q = -q;
        end else begin
            q = (y - (((y % d) + d) % d)) / d;
        end
        return wrapw(q, w);
    endfunction

    // One clock: drive at negedge, check outputs, advance the model for the coming edge
    task automatic tick();
        longint y1, y2, u;
        bit     slot, acc, exp_vld;
        @(negedge clk);
        rst        = rst_g;
        enable_cic = en_g;
        din_vld    = (src_q.size() > 0);
        din        = '0;
        if (din_vld) din = BIN'(src_q[0]);
        #1;
        if (!rst_g) begin
            if (just_rst) begin
                chk("rst_dout", dout, 0);
                chk("rst_cut", dout_cut, 0);
                chk("rst_dout2", dout2, 0);
`ifdef CIC_INT_UFLOW_EN
                chk("rst_uflow", uflow, 0);
`endif
                just_rst = 0;
            end
            chk("rdy", din_rdy, en_g && ph == 0);
            chk("rdy2", din_rdy2, en_g && ph == 0);
            exp_vld = en_g && (pcnt >= N + 1);
            chk("vld", dout_vld, exp_vld);
            chk("vld2", dout_vld2, exp_vld);
            if (en_g && din_rdy && din_vld) acc_cnt++;
            if (cap && dout_vld) cap1.push_back(dout);
            if (cap && dout_vld2) cap2.push_back(dout2);
            if (dout_vld) begin
                chk("q1_nonempty", q1.size() > 0, 1);
                if (q1.size() > 0) begin
                    y1 = q1.pop_front();
                    chk("dout", dout, y1);
                    chk("cut", dout_cut, cut_exp(y1, BOUT1 - COUT1, COUT1, 1'b1));
                    if (y1 == 6)  chk("rnd_p6", dout_cut, 2);
                    if (y1 == -6) chk("rnd_m6", dout_cut, -2);
                    if (y1 == -5) chk("rnd_m5", dout_cut, -1);
                end
            end else if (!en_g && pcnt >= N + 1 && q1.size() > 0) begin
                chk("frozen", dout, q1[0]);
            end
            if (dout_vld2) begin
                chk("q2_nonempty", q2.size() > 0, 1);
                if (q2.size() > 0) begin
                    y2 = q2.pop_front();
                    chk("dout2", dout2, y2);
                    chk("cut2", dout_cut2, cut_exp(y2, BOUT2 - COUT2, COUT2, 1'b0));
                    if (y2 == -5) chk("cut_m5", dout_cut2, -2);
                end
            end else if (!en_g && pcnt >= N + 1 && q2.size() > 0) begin
                chk("frozen2", dout2, q2[0]);
            end
`ifdef CIC_INT_UFLOW_EN
            chk("uflow", uflow, uflow_m);
            chk("uflow2", uflow2, uflow_m);
`endif
        end
        if (rst_g) begin
            ph = 0; pcnt = 0; primed_m = 0; uflow_m = 0; just_rst = 1;
            hist = {}; q1 = {}; q2 = {};
        end else if (en_g) begin
            slot = (ph == 0);
            acc  = slot && din_vld;
            u    = 0;
            if (slot && !din_vld && primed_m) uflow_m = 1;
            if (acc) begin
                u = src_q.pop_front();
                primed_m = 1;
            end
            hist.push_front(u);
            if (hist.size() > h2.size()) void'(hist.pop_back());
            if (primed_m) begin
                q1.push_back(wrapw(conv(1'b0), BOUT1));
                q2.push_back(wrapw(conv(1'b1), BOUT2));
                if (pcnt < N + 1) pcnt++;
            end
            ph = (ph == R - 1) ? 0 : ph + 1;
        end
        @(posedge clk);
    endtask

    task automatic drain(input int keep);
        int guard;
        guard = 0;
        while (src_q.size() > keep && guard < 4000) begin
            tick();
            guard++;
        end
        chk("drain_bound", src_q.size() <= keep, 1);
    endtask

    initial begin
        int     tbl[9];
        longint sum2, peak2;
        tbl = '{1, 2, 3, 4, 3, 2, 1, 0, 0};
        h1 = box_pow(R * M1);
        h2 = box_pow(R * M2);
        n_tests = 0; n_fail = 0; acc_cnt = 0; cap = 0;
        ph = 0; pcnt = 0; primed_m = 0; uflow_m = 0; just_rst = 0;
        rst = 1'b1; enable_cic = 1'b0; din = '0; din_vld = 1'b0;
        rst_g = 1; en_g = 1;

        repeat (3) tick();
        rst_g = 0;

        // Handshake: sample presented at phase 2 waits for phase 0; then impulse response
        for (int i = 0; i < R && ph != 2; i++) tick();
        acc_cnt = 0;
        src_q.push_back(1);
        repeat (20) src_q.push_back(0);
        cap = 1;
        repeat (2) tick();
        chk("hs_wait", acc_cnt, 0);
        tick();
        chk("hs_take", acc_cnt, 1);
        repeat (15) tick();
        chk("hs_rate", acc_cnt, 4);
        drain(2);
        cap = 0;
        chk("imp_len", cap1.size() >= 9, 1);
        for (int i = 0; i < 9 && i < cap1.size(); i++) chk($sformatf("imp[%0d]", i), cap1[i], tbl[i]);
        sum2 = 0; peak2 = 0;
        foreach (cap2[i]) begin
            sum2 += cap2[i];
            if (cap2[i] > peak2) peak2 = cap2[i];
        end
        chk("imp2_len", cap2.size() >= 15, 1);
        for (int i = 0; i < 15 && i < cap2.size(); i++)
            chk($sformatf("imp2[%0d]", i), cap2[i], 8 - ((i > 7) ? i - 7 : 7 - i));
        chk("imp2_sum", sum2, 64);
        chk("imp2_peak", peak2, 8);

        // Rounding: responses reach +6, -6 and -5
        src_q.push_back(2);  repeat (5) src_q.push_back(0);
        src_q.push_back(-2); repeat (5) src_q.push_back(0);
        src_q.push_back(-5); repeat (7) src_q.push_back(0);
        drain(2);

        // DC gain
        repeat (30) src_q.push_back(100);
        drain(20);
        #1;
        chk("dc_400", dout, 400);
        chk("dc_1600", dout2, 1600);
        chk("dc_vld", dout_vld, 1);

        // Enable low for 5 cycles mid-stream
        en_g = 0;
        repeat (5) tick();
        en_g = 1;
        drain(4);

        // Underflow: exactly one empty slot after priming
        drain(0);
        repeat (R) tick();
`ifdef CIC_INT_UFLOW_EN
        #1;
        chk("uflow_set", uflow, 1);
`endif
        repeat (8) src_q.push_back(50);
        drain(2);
`ifdef CIC_INT_UFLOW_EN
        #1;
        chk("uflow_sticky", uflow, 1);
`endif

        // Reset mid-stream discards everything in flight
        rst_g = 1;
        repeat (3) tick();
        src_q = {};
        rst_g = 0;
        repeat (2) tick();

        // Random samples with random enable gaps
        repeat (40) src_q.push_back($urandom_range(0, 1022) - 511);
        for (int i = 0; i < 2000 && src_q.size() > 0; i++) begin
            en_g = ($urandom_range(0, 9) != 0);
            tick();
        end
        en_g = 1;
        repeat (6) src_q.push_back(0);
        drain(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
